// File: rtl/timer_dev.sv
// timer_dev: programmable down-counting timer on the I/O bridge.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       asynchronous active-low reset
//   addr      word select: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved
//   we        write strobe from the bridge
//   be        byte enables for the write
//   din       write data
//   dout      combinational read data for addr (no read side effects)
//   irq       interrupt request = pending flag gated by CTRL.IM
//   dbg_state current FSM state, for observation only
//
// Register map:
//   CTRL[0]   En   : run enable; cleared by hardware when a one-shot expires
//   CTRL[2:1] Mode : 01 auto-reload, anything else one-shot
//   CTRL[3]   IM   : interrupt mask (1 = irq allowed out)
//
// Handshake: there is no ready; a write with we=1 is accepted on the rising
// edge it is sampled on, and dout is valid in the same cycle addr is driven.
module timer_dev #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         addr,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               irq,
  output logic [1:0]         dbg_state
);

  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               ctrl_en;
  logic [1:0]         ctrl_mode;
  logic               ctrl_im;
  logic [WIDTH-1:0]   preset;
  logic [WIDTH-1:0]   count, count_n;
  logic               irq_pend;

  logic               set_pend;
  logic               clr_pend;
  logic               clr_en;
  logic               wr_ctrl;
  logic               wr_preset;
  logic               auto_mode;

  assign wr_ctrl   = we && (addr == 2'd0) && be[0];
  assign wr_preset = we && (addr == 2'd1);
  // Mode 1x is treated as one-shot.
  assign auto_mode = (ctrl_mode == 2'b01);

  // Next-state and counter datapath.
  always_comb begin
    state_n  = state;
    count_n  = count;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    clr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en) state_n = LOAD;
      end
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_n = IDLE;
        end else if (count != '0) begin
          count_n = count - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          state_n  = INT;
          set_pend = 1'b1;
        end
      end
      INT: begin
        if (auto_mode) begin
          // Dropping the pending flag here makes the auto-reload irq a
          // single-cycle pulse.
          state_n  = LOAD;
          clr_pend = 1'b1;
        end else begin
          state_n = IDLE;
          clr_en  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      irq_pend  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;

      // A CPU write to CTRL takes precedence over the hardware En clear.
      if (wr_ctrl) begin
        ctrl_en   <= din[0];
        ctrl_mode <= din[2:1];
        ctrl_im   <= din[3];
      end else if (clr_en) begin
        ctrl_en <= 1'b0;
      end

      for (int i = 0; i < NB; i++) begin
        if (wr_preset && be[i]) preset[8*i +: 8] <= din[8*i +: 8];
      end

      // A new expiry is never lost to a simultaneous acknowledge; otherwise
      // any CTRL write acknowledges the pending interrupt.
      if (set_pend) begin
        irq_pend <= 1'b1;
      end else if (wr_ctrl || clr_pend) begin
        irq_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
      2'd1:    dout      = preset;
      2'd2:    dout      = count;
      default: dout      = '0;
    endcase
  end

  assign irq       = irq_pend & ctrl_im;
  assign dbg_state = state;

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev. Expected values come from the timer's timing rules:
// with PRESET=N and En written at edge t, COUNT=N after edge t+2, counts down
// by one per edge to 0, and irq appears after edge t+3+N; auto-reload repeats
// every N+3 edges.
module tb_timer_dev;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  timer_dev #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .we        (we),
    .be        (be),
    .din       (din),
    .dout      (dout),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write is accepted on the returned-after edge.
  task automatic bus_write(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    addr = a; be = b; din = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; be = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      n_cmp++;
      if (d !== 32'h0) begin n_err++; $display("FAIL reset_dout addr=%0d got=%h exp=0", a, d); end
    end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(1);
    // Mid-operation reset: COUNT at 5 with PRESET 9.
    bus_write(2'd1, 4'hF, 32'd9);
    bus_write(2'd0, 4'h1, 32'h9);
    step(6);
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd5) begin n_err++; $display("FAIL reset_precount got=%0d exp=5", d); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_async_irq got=%b exp=0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      n_cmp++;
      if (d !== 32'h0) begin n_err++; $display("FAIL reset_async_dout addr=%0d got=%h exp=0", a, d); end
    end
    @(negedge clk);
    rst = 1'b1;
    step(3);
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_no_restart count=%0d exp=0", d); end
  endtask

  task automatic test_one_shot(input int n);
    logic [31:0] d;
    logic [31:0] exp_c;
    bus_write(2'd1, 4'hF, n);
    bus_write(2'd0, 4'h1, 32'h9);
    for (int k = 1; k <= n + 8; k++) begin
      step(1);
      n_cmp++;
      if (irq !== (k >= n + 3)) begin
        n_err++; $display("FAIL oneshot_irq n=%0d k=%0d got=%b exp=%b", n, k, irq, (k >= n + 3));
      end
      if (k >= 2) begin
        exp_c = (k - 2 <= n) ? n - (k - 2) : 0;
        rd(2'd2, d);
        n_cmp++;
        if (d !== exp_c) begin n_err++; $display("FAIL oneshot_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, exp_c); end
      end
    end
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl got=%h exp=8", d); end
    bus_write(2'd0, 4'h1, 32'h8);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_ack got=%b exp=0", irq); end
    step(2);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_ack_hold got=%b exp=0", irq); end
  endtask

  task automatic test_auto_reload(input int n);
    logic [31:0] d;
    logic [31:0] exp_c;
    int p;
    int pulses;
    int period;
    period = n + 3;
    pulses = 0;
    bus_write(2'd1, 4'hF, n);
    bus_write(2'd0, 4'h1, 32'hB);
    for (int k = 1; k <= 5 * period; k++) begin
      step(1);
      n_cmp++;
      if (irq !== (k % period == 0)) begin
        n_err++; $display("FAIL auto_irq n=%0d k=%0d got=%b exp=%b", n, k, irq, (k % period == 0));
      end
      if (irq === 1'b1) pulses++;
      if (k >= 2) begin
        p = (k - 1) % period;
        exp_c = (p >= 1 && p <= n + 1) ? n - (p - 1) : 0;
        rd(2'd2, d);
        n_cmp++;
        if (d !== exp_c) begin n_err++; $display("FAIL auto_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, exp_c); end
      end
    end
    n_cmp++;
    if (pulses < 4) begin n_err++; $display("FAIL auto_pulses n=%0d got=%0d exp>=4", n, pulses); end
    bus_write(2'd0, 4'h1, 32'h0);
    step(4);
    bus_write(2'd0, 4'h1, 32'h0);
    step(1);
  endtask

  task automatic test_mask();
    logic [31:0] d;
    int bad;
    bad = 0;
    bus_write(2'd1, 4'hF, 32'd1);
    bus_write(2'd0, 4'h1, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq k=%0d got=%b exp=0", k, irq); end
    end
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL mask_ctrl got=%h exp=0", d); end
    bus_write(2'd0, 4'h1, 32'h8);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL mask_unmask k=%0d got=%b exp=0", k, irq); end
      step(1);
    end
    bus_write(2'd0, 4'h1, 32'h0);
  endtask

  task automatic test_pause();
    logic [31:0] d;
    bus_write(2'd1, 4'hF, 32'd10);
    bus_write(2'd0, 4'h1, 32'h9);
    step(5);
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd7) begin n_err++; $display("FAIL pause_pre got=%0d exp=7", d); end
    bus_write(2'd0, 4'h1, 32'h8);
    for (int k = 0; k < 20; k++) begin
      rd(2'd2, d);
      n_cmp++;
      if (d !== 32'd6) begin n_err++; $display("FAIL pause_frozen k=%0d got=%0d exp=6", k, d); end
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL pause_irq k=%0d got=%b exp=0", k, irq); end
      step(1);
    end
    bus_write(2'd0, 4'h1, 32'h9);
    step(1);
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd6) begin n_err++; $display("FAIL pause_load got=%0d exp=6", d); end
    step(1);
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'd10) begin n_err++; $display("FAIL pause_reload got=%0d exp=10", d); end
    bus_write(2'd0, 4'h1, 32'h0);
    step(3);
  endtask

  task automatic test_preset_midcount();
    logic [31:0] d;
    bus_write(2'd1, 4'hF, 32'd6);
    bus_write(2'd0, 4'h1, 32'h9);
    step(3);
    bus_write(2'd1, 4'hF, 32'd2); // edge k=4
    for (int k = 5; k <= 10; k++) begin
      step(1);
      if (k <= 8) begin
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'(8 - k)) begin n_err++; $display("FAIL midcount_count k=%0d got=%0d exp=%0d", k, d, 8 - k); end
      end
      n_cmp++;
      if (irq !== (k >= 9)) begin n_err++; $display("FAIL midcount_irq k=%0d got=%b exp=%b", k, irq, (k >= 9)); end
    end
    rd(2'd1, d);
    n_cmp++;
    if (d !== 32'd2) begin n_err++; $display("FAIL midcount_preset got=%0d exp=2", d); end
    bus_write(2'd0, 4'h1, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      n_cmp++;
      if (irq !== (k >= 5)) begin n_err++; $display("FAIL midcount_next_irq k=%0d got=%b exp=%b", k, irq, (k >= 5)); end
    end
    bus_write(2'd0, 4'h1, 32'h0);
  endtask

  task automatic test_mode_change();
    bus_write(2'd1, 4'hF, 32'd4);
    bus_write(2'd0, 4'h1, 32'hB);
    step(3);
    bus_write(2'd0, 4'h1, 32'h9); // edge k=4, during CNT
    for (int k = 5; k <= 12; k++) begin
      step(1);
      n_cmp++;
      if (irq !== (k >= 7)) begin n_err++; $display("FAIL modechg_irq k=%0d got=%b exp=%b", k, irq, (k >= 7)); end
    end
    bus_write(2'd0, 4'h1, 32'h0);
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [31:0] exp_p;
    logic [31:0] cnt0;
    logic [31:0] wd;
    logic [3:0]  wb;
    bus_write(2'd1, 4'hF, 32'h0);
    bus_write(2'd1, 4'h5, 32'hAABBCCDD);
    rd(2'd1, d);
    n_cmp++;
    if (d !== 32'h00BB00DD) begin n_err++; $display("FAIL be_preset got=%h exp=00bb00dd", d); end
    exp_p = 32'h00BB00DD;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      wb = 4'($urandom_range(0, 15));
      bus_write(2'd1, wb, wd);
      for (int b = 0; b < 4; b++) if (wb[b]) exp_p[8*b +: 8] = wd[8*b +: 8];
      rd(2'd1, d);
      n_cmp++;
      if (d !== exp_p) begin n_err++; $display("FAIL be_rand be=%b got=%h exp=%h", wb, d, exp_p); end
    end
    rd(2'd2, cnt0);
    bus_write(2'd2, 4'hF, 32'h12345678);
    rd(2'd2, d);
    n_cmp++;
    if (d !== cnt0) begin n_err++; $display("FAIL count_ro got=%h exp=%h", d, cnt0); end
    bus_write(2'd3, 4'hF, 32'hFFFFFFFF);
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reserved got=%h exp=0", d); end
    rd(2'd1, d);
    n_cmp++;
    if (d !== exp_p) begin n_err++; $display("FAIL reserved_side got=%h exp=%h", d, exp_p); end
    bus_write(2'd0, 4'hE, 32'h0000000F);
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_be0 got=%h exp=0", d); end
    bus_write(2'd0, 4'hF, 32'hFFFFFFF6);
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h6) begin n_err++; $display("FAIL ctrl_upper got=%h exp=6", d); end
    bus_write(2'd0, 4'h1, 32'h0);
    step(3);
  endtask

  task automatic test_max_preset();
    logic [31:0] d;
    bus_write(2'd1, 4'hF, 32'hFFFFFFFF);
    bus_write(2'd0, 4'h1, 32'h1);
    step(1);
    for (int k = 2; k <= 9; k++) begin
      step(1);
      rd(2'd2, d);
      n_cmp++;
      if (d !== 32'hFFFFFFFF - 32'(k - 2)) begin
        n_err++; $display("FAIL max_count k=%0d got=%h exp=%h", k, d, 32'hFFFFFFFF - 32'(k - 2));
      end
    end
    bus_write(2'd0, 4'h1, 32'h0);
    step(3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; we = 1'b0; addr = 2'd0; be = 4'h0; din = 32'h0;
    #1;
    test_reset();
    test_one_shot(3);
    test_one_shot($urandom_range(0, 20));
    test_auto_reload(2);
    test_auto_reload(0);
    test_auto_reload($urandom_range(1, 6));
    test_mask();
    test_pause();
    test_preset_midcount();
    test_mode_change();
    test_regs();
    test_max_preset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
